// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control: button conditioning, run/pause/lap FSM, display routing
// Optional lap/split feature: define STOPWATCH_LAP_EN to build the LAP state, lap registers and btn_lap path.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic       cnt_enable,
  output logic       cnt_clr,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [3:0] blank,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

`ifdef STOPWATCH_LAP_EN
  localparam logic LAP_EN = 1'b1;
`else
  localparam logic LAP_EN = 1'b0;
`endif

  // Counter value at which the DB_CYCLES-th consecutive mismatch is seen.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Button bit order: 0 = start/stop, 1 = clear, 2 = lap.
  logic [2:0]           btn_raw;
  logic [2:0]           sync1_q, sync1_d;
  logic [2:0]           sync2_q, sync2_d;
  logic [2:0]           level_q, level_d;
  logic [2:0]           level_prev_q, level_prev_d;
  logic [2:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]           press;
  logic                 press_ss, press_clr, press_lap;

  state_t               state_q, state_d;
  logic                 cnt_clr_q, cnt_clr_d;

  assign btn_raw = {btn_lap, btn_clr, btn_ss};

  // Synchronizer shift and per-button debounce counters.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    db_cnt_d     = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Button conditioning registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  // Rising edges of the debounced levels only; releases are silent.
  assign press     = level_q & ~level_prev_q;
  assign press_clr = press[1];
  assign press_ss  = press[0];
  assign press_lap = press[2] & LAP_EN;

  // Next state with clr > ss > lap priority; only the winning press is considered.
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    if (press_clr) begin
      if (state_q == S_IDLE || state_q == S_PAUSE) begin
        state_d   = S_IDLE;
        cnt_clr_d = 1'b1;
      end
    end else if (press_ss) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        S_LAP:   state_d = S_PAUSE;
        default: state_d = state_q;
      endcase
    end else if (press_lap) begin
      case (state_q)
        S_RUN:   state_d = S_LAP;
        S_LAP:   state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM state and registered counter-clear pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign state      = state_q;
  assign cnt_enable = (state_q == S_RUN) || (state_q == S_LAP);
  assign cnt_clr    = cnt_clr_q;

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_q, lap_d;

  // Freeze the live digits on the RUN->LAP edge.
  always_comb begin
    lap_d = lap_q;
    if (state_q == S_RUN && state_d == S_LAP) begin
      lap_d = {d3, d2, d1, d0};
    end
  end

  // Lap register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign {q3, q2, q1, q0} = (state_q == S_LAP) ? lap_q : {d3, d2, d1, d0};
`else
  assign {q3, q2, q1, q0} = {d3, d2, d1, d0};
`endif

  // Leading-zero blanking; the least significant digit is always shown.
  assign blank[3] = (q3 == 4'd0);
  assign blank[2] = blank[3] & (q2 == 4'd0);
  assign blank[1] = blank[2] & (q1 == 4'd0);
  assign blank[0] = 1'b0;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with random button stimulus
module tb_stopwatch_ctrl;

  localparam int DBC = 4;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
  logic [15:0] cur_d = 16'h0000;
  logic [3:0]  d0, d1, d2, d3;
  logic        cnt_enable, cnt_clr;
  logic [3:0]  q0, q1, q2, q3, blank;
  logic [1:0]  state;

  assign {d3, d2, d1, d0} = cur_d;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DB_CYCLES(DBC), .DB_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .cnt_enable(cnt_enable), .cnt_clr(cnt_clr),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .blank(blank), .state(state)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  st;
    logic        clr;
    logic        lap_on;
    logic [15:0] lap_val;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: state as an integer, transition table indexed [state][button]
  // with button 0=ss 1=clr 2=lap; -1 means the press has no effect.
  int          tbl[4][3];
  int          m_state = 0;
  logic [15:0] m_lap = 16'h0000;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_blank(logic [15:0] qv);
    logic [3:0] b;
    logic       all_zero;
    b = 4'b0000;
    all_zero = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      all_zero = all_zero && (qv[i*4 +: 4] == 4'd0);
      b[i] = all_zero;
    end
    return b;
  endfunction

  task automatic model_press(logic [2:0] mask);
    int  b;
    int  nxt;
    ev_t e;
    if (mask[1]) b = 1;
    else if (mask[0]) b = 0;
    else if (mask[2] && LAP_EN) b = 2;
    else return;
    nxt = tbl[m_state][b];
    if (nxt < 0) return;
    if (m_state == 1 && nxt == 3) m_lap = cur_d;
    e.st      = 2'(nxt);
    e.clr     = (b == 1);
    e.lap_on  = (nxt == 3);
    e.lap_val = m_lap;
    m_state   = nxt;
    exp_q.push_back(e);
  endtask

  // One button operation: new digits, buttons held for 'hold' edges, then idle gap.
  task automatic do_op(logic [2:0] mask, int hold, logic [15:0] dv);
    @(posedge clk); #1;
    cur_d = dv;
    if (mask != 3'b000 && hold >= DBC) model_press(mask);
    {btn_lap, btn_clr, btn_ss} = mask;
    repeat (hold) @(posedge clk);
    #1;
    {btn_lap, btn_clr, btn_ss} = 3'b000;
    repeat (14) @(posedge clk);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  // Monitor: pops an expected event whenever the DUT changes state or pulses cnt_clr,
  // and checks the display path every cycle against the model's view.
  initial begin
    logic [1:0]  prev_st;
    logic [1:0]  view_st;
    logic        view_lap;
    logic [15:0] view_val;
    logic [15:0] exp_qv;
    ev_t         e;
    prev_st  = 2'b00;
    view_st  = 2'b00;
    view_lap = 1'b0;
    view_val = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_st  = 2'b00;
        view_st  = 2'b00;
        view_lap = 1'b0;
      end else begin
        if (state !== prev_st || cnt_clr !== 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event_state", {30'd0, state}, {30'd0, prev_st});
            chk("unexpected_event_cnt_clr", {31'd0, cnt_clr}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("event_state", {30'd0, state}, {30'd0, e.st});
            chk("event_cnt_clr", {31'd0, cnt_clr}, {31'd0, e.clr});
            view_st  = e.st;
            view_lap = e.lap_on;
            view_val = e.lap_val;
          end
          prev_st = state;
        end
        chk("cnt_enable", {31'd0, cnt_enable}, {31'd0, (view_st == 2'b01 || view_st == 2'b11)});
        exp_qv = view_lap ? view_val : cur_d;
        chk("q_digits", {16'd0, q3, q2, q1, q0}, {16'd0, exp_qv});
        chk("blank", {28'd0, blank}, {28'd0, exp_blank(exp_qv)});
      end
    end
  end

  initial begin
    int k;
    logic [2:0] mask;
    int hold;

    for (int s = 0; s < 4; s++) for (int b = 0; b < 3; b++) tbl[s][b] = -1;
    tbl[0][0] = 1; tbl[1][0] = 2; tbl[2][0] = 1; tbl[3][0] = 2;
    tbl[0][1] = 0; tbl[2][1] = 0;
    tbl[1][2] = 3; tbl[3][2] = 1;

    // Reset state with all-zero digits.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_cnt_enable", {31'd0, cnt_enable}, 32'd0);
    chk("reset_cnt_clr", {31'd0, cnt_clr}, 32'd0);
    chk("reset_blank", {28'd0, blank}, 32'b1110);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Directed walk through the main transitions.
    do_op(3'b001, 10, 16'h0000);     // IDLE -> RUN
    do_op(3'b001, DBC - 1, 16'h0000); // glitch, ignored
    do_op(3'b010, 10, 16'h0007);     // clr in RUN ignored
    do_op(3'b001, 10, 16'h0007);     // RUN -> PAUSE
    do_op(3'b010, 10, 16'h0007);     // PAUSE -> IDLE with cnt_clr
    do_op(3'b010, 10, 16'h0000);     // IDLE clr, cnt_clr only
    do_op(3'b001, DBC, 16'h0000);    // minimum-length press -> RUN
    do_op(3'b001, 10, 16'h0010);     // RUN -> PAUSE
    do_op(3'b011, 10, 16'h0010);     // ss+clr in PAUSE -> IDLE with cnt_clr
    do_op(3'b001, 10, 16'h0123);     // IDLE -> RUN
    do_op(3'b100, 10, 16'h0123);     // lap
    do_op(3'b000, 0, 16'h0456);      // digits move on
    do_op(3'b100, 10, 16'h0456);     // lap again
    do_op(3'b000, 0, 16'hA0B0);      // non-BCD digits pass through
    do_op(3'b101, 10, 16'h00C0);     // ss beats lap

    // Random operations.
    for (int n = 0; n < 70; n++) begin
      mask = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DBC - 1) : $urandom_range(DBC, 10);
      do_op(mask, hold, rand_digits());
    end

    // Reset during a debounce with the button held through release.
    chk("queue_empty_before_reset", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    btn_ss = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_state = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_press(3'b001);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (state == 2'b01) begin
        k = i;
        break;
      end
    end
    chk("press_after_reset_latency", k, DBC + 3);
    btn_ss = 1'b0;
    repeat (14) @(posedge clk);

    for (int n = 0; n < 20; n++) begin
      mask = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DBC - 1) : $urandom_range(DBC, 10);
      do_op(mask, hold, rand_digits());
    end

    repeat (20) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
